rr_mux_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer for the 4:1 WIDTH-bit select datapath.

---
 rtl/rr_mux_arbiter.sv | 149 ++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for four req/gnt requesters feeding one registered
// valid/ready output channel, with a stall watchdog that drops a held word.
module rr_mux_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] data_c,
    input  logic [WIDTH-1:0] data_d,
    output logic [3:0]       gnt,
    output logic [1:0]       select,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             error
);

    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : {CW{1'b0}};
    localparam logic [CW-1:0] WAIT_SAT  = {CW{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_r, state_n;
    logic [1:0]       ptr_r, ptr_n;
    logic [CW-1:0]    wait_cnt_r, wait_cnt_n;
    logic [WIDTH-1:0] out_data_r, out_data_n;
    logic [1:0]       select_r, select_n;
    logic             out_valid_r, out_valid_n;
    logic             error_r, error_n;

    logic [1:0]       winner_s;
    logic [WIDTH-1:0] winner_data_s;
    logic             xfer_s;
    logic             timeout_s;
    logic             take_s;
    logic [3:0]       gnt_s;

    // Round-robin search starting at ptr; 2-bit index wraps modulo 4.
    always_comb begin
        logic [1:0] idx_v;
        logic       found_v;
        idx_v    = ptr_r;
        found_v  = 1'b0;
        winner_s = ptr_r;
        for (int o = 0; o < 4; o++) begin
            idx_v = ptr_r + 2'(o);
            if (!found_v && req[idx_v]) begin
                winner_s = idx_v;
                found_v  = 1'b1;
            end else begin
                found_v  = found_v;
            end
        end
    end

    // Word multiplexer driven by the arbitration winner.
    always_comb begin
        case (winner_s)
            2'd0:    winner_data_s = data_a;
            2'd1:    winner_data_s = data_b;
            2'd2:    winner_data_s = data_c;
            2'd3:    winner_data_s = data_d;
            default: winner_data_s = data_a;
        endcase
    end

    assign xfer_s    = (state_r == BUSY) && out_ready;
    assign timeout_s = (MAX_WAIT > 0) && (state_r == BUSY) && !out_ready &&
                       (wait_cnt_r == WAIT_LAST);
    assign take_s    = (|req) && ((state_r == IDLE) || xfer_s) && !timeout_s;

    // Grant decode; gnt doubles as the requester's ready for this edge.
    always_comb begin
        if (take_s) begin
            gnt_s = 4'b0001 << winner_s;
        end else begin
            gnt_s = 4'b0000;
        end
    end

    // Next-state and next-output logic for the IDLE/BUSY sequencer.
    always_comb begin
        state_n     = state_r;
        ptr_n       = ptr_r;
        wait_cnt_n  = wait_cnt_r;
        out_data_n  = out_data_r;
        select_n    = select_r;
        out_valid_n = out_valid_r;
        error_n     = 1'b0;
        if (take_s) begin
            state_n     = BUSY;
            ptr_n       = winner_s + 2'd1;
            wait_cnt_n  = {CW{1'b0}};
            out_data_n  = winner_data_s;
            select_n    = winner_s;
            out_valid_n = 1'b1;
        end else if (xfer_s || timeout_s) begin
            // Transfer without a follow-up word, or watchdog drop; ptr is kept.
            state_n     = IDLE;
            wait_cnt_n  = {CW{1'b0}};
            out_valid_n = 1'b0;
            error_n     = timeout_s;
        end else if (state_r == BUSY) begin
            if (wait_cnt_r != WAIT_SAT) begin
                wait_cnt_n = wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                wait_cnt_n = wait_cnt_r;
            end
        end else begin
            state_n = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= 2'd0;
            wait_cnt_r  <= {CW{1'b0}};
            out_data_r  <= {WIDTH{1'b0}};
            select_r    <= 2'd0;
            out_valid_r <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_n;
            ptr_r       <= ptr_n;
            wait_cnt_r  <= wait_cnt_n;
            out_data_r  <= out_data_n;
            select_r    <= select_n;
            out_valid_r <= out_valid_n;
            error_r     <= error_n;
        end
    end

    assign gnt       = gnt_s;
    assign select    = select_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign error     = error_r;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench: three arbiters (MAX_WAIT 15, 3, 0) share stimulus and are
// each compared against a behavioural round-robin model.
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] da, db, dc, dd;
    logic       out_ready;

    logic [2:0][3:0] gnt_o;
    logic [2:0][1:0] sel_o;
    logic [2:0][7:0] odata_o;
    logic [2:0]      valid_o;
    logic [2:0]      err_o;

    rr_mux_arbiter #(.WIDTH(8), .MAX_WAIT(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .data_a(da), .data_b(db), .data_c(dc), .data_d(dd),
        .gnt(gnt_o[0]), .select(sel_o[0]), .out_data(odata_o[0]),
        .out_valid(valid_o[0]), .out_ready(out_ready), .error(err_o[0]));

    rr_mux_arbiter #(.WIDTH(8), .MAX_WAIT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .data_a(da), .data_b(db), .data_c(dc), .data_d(dd),
        .gnt(gnt_o[1]), .select(sel_o[1]), .out_data(odata_o[1]),
        .out_valid(valid_o[1]), .out_ready(out_ready), .error(err_o[1]));

    rr_mux_arbiter #(.WIDTH(8), .MAX_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .data_a(da), .data_b(db), .data_c(dc), .data_d(dd),
        .gnt(gnt_o[2]), .select(sel_o[2]), .out_data(odata_o[2]),
        .out_valid(valid_o[2]), .out_ready(out_ready), .error(err_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model state per instance.
    int         mw      [3] = '{15, 3, 0};
    bit         m_busy  [3];
    int         m_ptr   [3];
    int         m_stall [3];
    bit         m_err   [3];
    logic [3:0] exp_gnt [3];
    bit         exp_valid [3];
    bit         exp_err [3];

    // Scoreboard queues of captured {select, word}.
    logic [9:0] q0[$], q1[$], q2[$];

    task automatic q_push(input int k, input logic [9:0] v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    function automatic int q_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [9:0] q_front(input int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic q_pop(input int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] word_of(input int w);
        case (w)
            0:       return da;
            1:       return db;
            2:       return dc;
            default: return dd;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_busy[k]    = 1'b0;
            m_ptr[k]     = 0;
            m_stall[k]   = 0;
            m_err[k]     = 1'b0;
            exp_gnt[k]   = 4'b0000;
            exp_valid[k] = 1'b0;
            exp_err[k]   = 1'b0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    // One cycle of the spec rules: predicts this cycle's outputs, then advances.
    task automatic model_step(input int k);
        bit tmo, xf, tk;
        int w;
        exp_valid[k] = m_busy[k];
        exp_err[k]   = m_err[k];
        tmo = (mw[k] != 0) && m_busy[k] && !out_ready && (m_stall[k] == mw[k] - 1);
        xf  = m_busy[k] && out_ready;
        tk  = (req != 4'b0000) && (!m_busy[k] || xf) && !tmo;
        w = -1;
        for (int o = 0; o < 4; o++) begin
            if (w < 0 && req[(m_ptr[k] + o) % 4]) w = (m_ptr[k] + o) % 4;
        end
        exp_gnt[k] = tk ? 4'(1 << w) : 4'b0000;
        m_err[k]   = tmo;
        if (tk) begin
            q_push(k, {2'(w), word_of(w)});
            m_busy[k]  = 1'b1;
            m_ptr[k]   = (w + 1) % 4;
            m_stall[k] = 0;
        end else if (xf || tmo) begin
            m_busy[k]  = 1'b0;
            m_stall[k] = 0;
        end else if (m_busy[k]) begin
            m_stall[k] = m_stall[k] + 1;
        end
    endtask

    // Apply inputs just after a rising edge, predict, then advance one cycle.
    task automatic drive(input logic [3:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
        for (int k = 0; k < 3; k++) model_step(k);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        da = a; db = b; dc = c; dd = d;
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 3; k++) begin
            chk("rst_gnt",   k, 32'(gnt_o[k]),   32'd0);
            chk("rst_sel",   k, 32'(sel_o[k]),   32'd0);
            chk("rst_data",  k, 32'(odata_o[k]), 32'd0);
            chk("rst_valid", k, 32'(valid_o[k]), 32'd0);
            chk("rst_error", k, 32'(err_o[k]),   32'd0);
        end
    endtask

    task automatic apply_reset();
        chk_en    = 1'b0;
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: compares grants/flags every cycle and pops words as they leave.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk("gnt",   k, 32'(gnt_o[k]),   32'(exp_gnt[k]));
                chk("valid", k, 32'(valid_o[k]), 32'(exp_valid[k]));
                chk("error", k, 32'(err_o[k]),   32'(exp_err[k]));
                if (exp_err[k] && q_size(k) > 0) q_pop(k);
                if (exp_valid[k]) begin
                    chk("sb_depth", k, 32'(q_size(k) > 0), 32'd1);
                    if (q_size(k) > 0) begin
                        chk("word", k, {22'd0, sel_o[k], odata_o[k]}, {22'd0, q_front(k)});
                        if (out_ready) q_pop(k);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req = 4'b0000;
        out_ready = 1'b0;
        set_data(8'h00, 8'h00, 8'h00, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // Reset while a word is held, then a single request for C.
        set_data(8'h5A, 8'h6B, 8'h7C, 8'h8D);
        drive(4'b0001, 1'b0);
        drive(4'b0000, 1'b0);
        apply_reset();
        drive(4'b0100, 1'b0);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b1);

        // Fairness with all four requesting and a ready consumer.
        apply_reset();
        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        repeat (6) drive(4'b1111, 1'b1);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b1);

        // Pointer wrap: D, then A and D together.
        drive(4'b1000, 1'b1);
        drive(4'b1001, 1'b1);
        drive(4'b1001, 1'b1);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b1);

        // Backpressure on a held A5 with other requesters waiting.
        set_data(8'hA5, 8'h22, 8'h33, 8'h44);
        drive(4'b0001, 1'b0);
        repeat (5) drive(4'b1111, 1'b0);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b1);

        // Watchdog drop of 3C, then a normal grant to B.
        set_data(8'h3C, 8'h4D, 8'h5E, 8'h6F);
        drive(4'b0001, 1'b0);
        repeat (4) drive(4'b0000, 1'b0);
        drive(4'b0010, 1'b1);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b1);

        // Long stall: only the MAX_WAIT=0 instance keeps its word.
        set_data(8'hC3, 8'hD4, 8'hE5, 8'hF6);
        drive(4'b0100, 1'b0);
        repeat (100) drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b1);

        // Randomised traffic with alternating light and heavy backpressure.
        for (int i = 0; i < 400; i++) begin
            set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            drive(4'($urandom_range(0, 15)),
                  ((i % 100) < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0));
        end
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
